// File: rtl/pipeline_sequencer_if.sv
// Sequencer control bundle: debug-unit commands, hazard inputs, pipeline enables, state debug.
// The o_cycles member exists only when PIPE_CYCLE_COUNT_EN is defined.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
);
  logic i_start;
  logic i_step;
  logic i_stop;
  logic i_not_load;
  logic i_jmp_stop;
  logic i_halt;
  logic o_pc_en;
  logic o_if_id_en;
  logic o_if_id_flush;
  logic o_id_ex_flush;
  logic o_stage_en;
  logic o_busy;
  logic o_end;
  logic [2:0] dbg_state;
`ifdef PIPE_CYCLE_COUNT_EN
  logic [CNT_W-1:0] o_cycles;

  modport slave (
    input  i_start, i_step, i_stop, i_not_load, i_jmp_stop, i_halt,
    output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_stage_en,
    output o_busy, o_end, dbg_state, o_cycles
  );
  modport master (
    output i_start, i_step, i_stop, i_not_load, i_jmp_stop, i_halt,
    input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_stage_en,
    input  o_busy, o_end, dbg_state, o_cycles
  );
`else
  modport slave (
    input  i_start, i_step, i_stop, i_not_load, i_jmp_stop, i_halt,
    output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_stage_en,
    output o_busy, o_end, dbg_state
  );
  modport master (
    output i_start, i_step, i_stop, i_not_load, i_jmp_stop, i_halt,
    input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_stage_en,
    input  o_busy, o_end, dbg_state
  );
`endif
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline; drains in-flight instructions after HALT.
// Optional feature macro: PIPE_CYCLE_COUNT_EN adds the o_cycles enabled-cycle counter.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic i_clk,
  input  logic i_reset,
  pipeline_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       pc_en, if_id_en, if_id_flush, id_ex_flush, stage_en;
  logic       active;
  logic       rearm;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stage_en    = 1'b0;
    active      = 1'b0;
    rearm       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start)     state_d = RUN;
        else if (bus.i_step) state_d = STEP;
      end
      RUN: begin
        // A stop cycle freezes the pipeline outright, even if HALT is in ID.
        if (bus.i_stop) state_d = IDLE;
        else            active  = 1'b1;
      end
      STEP: begin
        active  = 1'b1;
        state_d = IDLE;
      end
      DRAIN: begin
        stage_en    = 1'b1;
        id_ex_flush = 1'b1;
        if (drain_cnt_q == 4'd0) state_d = DONE;
        else                     drain_cnt_d = drain_cnt_q - 4'd1;
      end
      DONE: begin
        if (bus.i_stop) begin
          state_d = IDLE;
          rearm   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (active) begin
      stage_en = 1'b1;
      if (bus.i_halt) begin
        // HALT flows down into ID/EX while fetch freezes; DRAIN_CYCLES cycles follow.
        drain_cnt_d = DRAIN_INIT;
        state_d     = DRAIN;
      end else if (!bus.i_not_load) begin
        id_ex_flush = 1'b1;
      end else if (bus.i_jmp_stop) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  assign bus.o_pc_en       = pc_en;
  assign bus.o_if_id_en    = if_id_en;
  assign bus.o_if_id_flush = if_id_flush;
  assign bus.o_id_ex_flush = id_ex_flush;
  assign bus.o_stage_en    = stage_en;
  assign bus.o_busy        = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);
  assign bus.o_end         = (state_q == DONE);
  assign bus.dbg_state     = state_q;

`ifdef PIPE_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycles_q, cycles_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cycles_q <= '0;
    else          cycles_q <= cycles_d;
  end

  always_comb begin
    cycles_d = cycles_q + CNT_W'(stage_en);
    if (rearm) cycles_d = '0;
  end

  assign bus.o_cycles = cycles_q;
`else
  logic unused_rearm;
  assign unused_rearm = rearm;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: run, stall, jump, halt/drain, stop, step, async reset.
module tb_pipeline_sequencer;
  localparam int DRAIN_CYCLES = 4;
  localparam int CNT_W        = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_flush, stage_en, busy, end}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_RUN   = 7'b1100110;
  localparam logic [6:0] O_STALL = 7'b0001110;
  localparam logic [6:0] O_JMP   = 7'b1110110;
  localparam logic [6:0] O_HALT  = 7'b0000110;
  localparam logic [6:0] O_DRAIN = 7'b0001110;
  localparam logic [6:0] O_STOP  = 7'b0000010;
  localparam logic [6:0] O_DONE  = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_cycles = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(CNT_W)) dut_if ();

  pipeline_sequencer #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (dut_if.slave)
  );

  function automatic logic [6:0] outs();
    return {dut_if.o_pc_en, dut_if.o_if_id_en, dut_if.o_if_id_flush, dut_if.o_id_ex_flush,
            dut_if.o_stage_en, dut_if.o_busy, dut_if.o_end};
  endfunction

  task automatic drive(input logic st, input logic sp, input logic so,
                       input logic nl, input logic jp, input logic hl);
    @(negedge clk);
    dut_if.i_start    = st;
    dut_if.i_step     = sp;
    dut_if.i_stop     = so;
    dut_if.i_not_load = nl;
    dut_if.i_jmp_stop = jp;
    dut_if.i_halt     = hl;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if (outs() !== O_IDLE) begin
      $display("FAIL reset_outs got=%b exp=%b", outs(), O_IDLE); bad++;
    end
    total++;
    if (dut_if.dbg_state !== ST_IDLE) begin
      $display("FAIL reset_state got=%0d exp=%0d", dut_if.dbg_state, ST_IDLE); bad++;
    end
`ifdef PIPE_CYCLE_COUNT_EN
    total++;
    if (dut_if.o_cycles !== '0) begin
      $display("FAIL reset_cycles got=%0d exp=0", dut_if.o_cycles); bad++;
    end
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (dut_if.dbg_state !== ST_IDLE || outs() !== O_IDLE) begin
      $display("FAIL idle_stop_ignored state=%0d outs=%b exp_state=%0d exp_outs=%b",
               dut_if.dbg_state, outs(), ST_IDLE, O_IDLE); bad++;
    end
  endtask

  task automatic test_run();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== O_IDLE) begin
      $display("FAIL run_start_cycle got=%b exp=%b", outs(), O_IDLE); bad++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_cycles++;
      total++;
      if (outs() !== O_RUN) begin
        $display("FAIL run_cycle%0d got=%b exp=%b", i, outs(), O_RUN); bad++;
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_cycles++;
      total++;
      if (outs() !== O_STALL) begin
        $display("FAIL stall_cycle%0d got=%b exp=%b", i, outs(), O_STALL); bad++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cycles++;
    total++;
    if (outs() !== O_RUN || dut_if.dbg_state !== ST_RUN) begin
      $display("FAIL stall_release outs=%b state=%0d exp_outs=%b exp_state=%0d",
               outs(), dut_if.dbg_state, O_RUN, ST_RUN); bad++;
    end
  endtask

  task automatic test_jump();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_cycles++;
    total++;
    if (outs() !== O_JMP) begin
      $display("FAIL jump_squash got=%b exp=%b", outs(), O_JMP); bad++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cycles++;
    total++;
    if (outs() !== O_STALL) begin
      $display("FAIL jump_vs_stall got=%b exp=%b", outs(), O_STALL); bad++;
    end
  endtask

  task automatic test_halt_drain();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_cycles++;
    total++;
    if (outs() !== O_HALT) begin
      $display("FAIL halt_cycle got=%b exp=%b", outs(), O_HALT); bad++;
    end
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      drive(i == 1, i == 2, i == 3, 1'b0, 1'b1, 1'b1);
      exp_cycles++;
      total++;
      if (outs() !== O_DRAIN || dut_if.dbg_state !== ST_DRAIN) begin
        $display("FAIL drain_cycle%0d outs=%b state=%0d exp_outs=%b exp_state=%0d",
                 i, outs(), dut_if.dbg_state, O_DRAIN, ST_DRAIN); bad++;
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== O_DONE || dut_if.dbg_state !== ST_DONE) begin
      $display("FAIL done_entry outs=%b state=%0d exp_outs=%b exp_state=%0d",
               outs(), dut_if.dbg_state, O_DONE, ST_DONE); bad++;
    end
`ifdef PIPE_CYCLE_COUNT_EN
    total++;
    if (dut_if.o_cycles !== CNT_W'(exp_cycles)) begin
      $display("FAIL done_cycles got=%0d exp=%0d", dut_if.o_cycles, exp_cycles); bad++;
    end
`endif
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== O_DONE) begin
      $display("FAIL done_hold got=%b exp=%b", outs(), O_DONE); bad++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cycles = 0;
    total++;
    if (outs() !== O_IDLE || dut_if.dbg_state !== ST_IDLE) begin
      $display("FAIL done_rearm outs=%b state=%0d exp_outs=%b exp_state=%0d",
               outs(), dut_if.dbg_state, O_IDLE, ST_IDLE); bad++;
    end
`ifdef PIPE_CYCLE_COUNT_EN
    total++;
    if (dut_if.o_cycles !== '0) begin
      $display("FAIL rearm_cycles got=%0d exp=0", dut_if.o_cycles); bad++;
    end
`endif
  endtask

  task automatic test_stop();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cycles++;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (outs() !== O_STOP) begin
      $display("FAIL stop_over_halt got=%b exp=%b", outs(), O_STOP); bad++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== O_IDLE || dut_if.dbg_state !== ST_IDLE) begin
      $display("FAIL stop_to_idle outs=%b state=%0d exp_outs=%b exp_state=%0d",
               outs(), dut_if.dbg_state, O_IDLE, ST_IDLE); bad++;
    end
  endtask

  task automatic test_step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cycles++;
    total++;
    if (dut_if.dbg_state !== ST_RUN || outs() !== O_RUN) begin
      $display("FAIL start_beats_step state=%0d outs=%b exp_state=%0d exp_outs=%b",
               dut_if.dbg_state, outs(), ST_RUN, O_RUN); bad++;
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cycles++;
    total++;
    if (dut_if.dbg_state !== ST_STEP || outs() !== O_RUN) begin
      $display("FAIL step_active state=%0d outs=%b exp_state=%0d exp_outs=%b",
               dut_if.dbg_state, outs(), ST_STEP, O_RUN); bad++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (dut_if.dbg_state !== ST_IDLE || outs() !== O_IDLE) begin
      $display("FAIL step_back_idle state=%0d outs=%b exp_state=%0d exp_outs=%b",
               dut_if.dbg_state, outs(), ST_IDLE, O_IDLE); bad++;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_cycles++;
    total++;
    if (outs() !== O_HALT) begin
      $display("FAIL step_halt got=%b exp=%b", outs(), O_HALT); bad++;
    end
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_cycles++;
      total++;
      if (dut_if.dbg_state !== ST_DRAIN || outs() !== O_DRAIN) begin
        $display("FAIL step_drain%0d state=%0d outs=%b exp_state=%0d exp_outs=%b",
                 i, dut_if.dbg_state, outs(), ST_DRAIN, O_DRAIN); bad++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (dut_if.dbg_state !== ST_DONE) begin
      $display("FAIL step_done got=%0d exp=%0d", dut_if.dbg_state, ST_DONE); bad++;
    end
`ifdef PIPE_CYCLE_COUNT_EN
    total++;
    if (dut_if.o_cycles !== CNT_W'(exp_cycles)) begin
      $display("FAIL step_cycles got=%0d exp=%0d", dut_if.o_cycles, exp_cycles); bad++;
    end
`endif
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_cycles = 0;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_cycles = 0;
    total++;
    if (outs() !== O_IDLE || dut_if.dbg_state !== ST_IDLE) begin
      $display("FAIL reset_mid_run outs=%b state=%0d exp_outs=%b exp_state=%0d",
               outs(), dut_if.dbg_state, O_IDLE, ST_IDLE); bad++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== O_IDLE || dut_if.dbg_state !== ST_IDLE) begin
      $display("FAIL reset_no_drain outs=%b state=%0d exp_outs=%b exp_state=%0d",
               outs(), dut_if.dbg_state, O_IDLE, ST_IDLE); bad++;
    end
`ifdef PIPE_CYCLE_COUNT_EN
    total++;
    if (dut_if.o_cycles !== '0) begin
      $display("FAIL reset_mid_cycles got=%0d exp=0", dut_if.o_cycles); bad++;
    end
`endif
  endtask

  initial begin
    dut_if.i_start    = 1'b0;
    dut_if.i_step     = 1'b0;
    dut_if.i_stop     = 1'b0;
    dut_if.i_not_load = 1'b1;
    dut_if.i_jmp_stop = 1'b0;
    dut_if.i_halt     = 1'b0;
    test_reset();
    test_run();
    test_stall();
    test_jump();
    test_halt_drain();
    test_stop();
    test_step();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
